wishbone_master: RTL and testbench

WISHBONE_MASTER -- requirements
Module: wishbone_master

---
 rtl/wishbone_master_pkg.sv | 12 +
 rtl/wishbone_master.sv | 104 ++++++++++
 tb/tb_wishbone_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_master_pkg.sv
// rtl/wishbone_master_pkg.sv - shared state encoding and default timeout for the Wishbone master
package wishbone_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wishbone_master.sv
// rtl/wishbone_master.sv - single-transaction Wishbone master with ack timeout
module wishbone_master
    import wishbone_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        sel_o,
    input  logic        ack_i
);

    // Counter value on which a still-unacknowledged cycle is abandoned.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    wb_state_t  state;
    logic [7:0] wait_cnt;

    // Request/bus/response sequencing. The bus output registers double as the
    // latched request: they are loaded on accept, held through BUS and cleared
    // when the cycle ends, so the address and data cannot drift mid-cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            wait_cnt     <= 8'd0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
            addr_o       <= 32'd0;
            data_o       <= 32'd0;
            we_o         <= 1'b0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            sel_o        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid_o <= 1'b0;
                    if (req_valid_i) begin
                        state       <= ST_BUS;
                        wait_cnt    <= 8'd0;
                        req_ready_o <= 1'b0;
                        addr_o      <= req_addr_i;
                        data_o      <= req_we_i ? req_wdata_i : 32'd0;
                        we_o        <= req_we_i;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        sel_o       <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // Ack wins over a timeout landing on the same edge.
                    if (ack_i || wait_cnt == LAST_CNT) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= (ack_i && !we_o) ? data_i : 32'd0;
                        resp_err_o   <= !ack_i;
                        addr_o       <= 32'd0;
                        data_o       <= 32'd0;
                        we_o         <= 1'b0;
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        sel_o        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_o <= 1'b0;
                    req_ready_o  <= 1'b1;
                end
                default: begin
                    state        <= ST_IDLE;
                    wait_cnt     <= 8'd0;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    addr_o       <= 32'd0;
                    data_o       <= 32'd0;
                    we_o         <= 1'b0;
                    cyc_o        <= 1'b0;
                    stb_o        <= 1'b0;
                    sel_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// tb/tb_wishbone_master.sv - self-checking bench for wishbone_master
module tb_wishbone_master;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_we_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        sel_o;
    logic        ack_i;

    int checks = 0;
    int failures = 0;

    wishbone_master #(.TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_we_i    (req_we_i),
        .resp_valid_o(resp_valid_o),
        .resp_rdata_o(resp_rdata_o),
        .resp_err_o  (resp_err_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i),
        .we_o        (we_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .sel_o       (sel_o),
        .ack_i       (ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Runs one transaction from a negedge. The slave acks during the ack_at-th
    // cycle that cyc_o is high (0 = never). Everything is observed at negedges.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic w,
                          input int ack_at, input logic [31:0] sd,
                          output int cyc_n, output int first_t, output int resp_n,
                          output int resp_t, output logic [31:0] rd, output logic er,
                          output logic [31:0] rd_hold, output logic er_hold,
                          output bit bus_ok, output logic ready_after);
        int stop_t;
        cyc_n = 0; first_t = -1; resp_n = 0; resp_t = -1; rd = 'x; er = 'x;
        rd_hold = 'x; er_hold = 'x; bus_ok = 1; ready_after = 1'b0; stop_t = 40;
        req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = wd; req_we_i = w;
        for (int t = 1; t <= 40 && t <= stop_t; t++) begin
            @(negedge clk_i);
            if (cyc_o) begin
                cyc_n++;
                if (first_t < 0) first_t = t;
                req_valid_i = 1'b0;
                if (addr_o !== a || data_o !== (w ? wd : 32'd0) || we_o !== w ||
                    stb_o !== 1'b1 || sel_o !== 1'b1 || req_ready_o !== 1'b0 ||
                    resp_valid_o !== 1'b0)
                    bus_ok = 0;
                ack_i  = (cyc_n == ack_at);
                data_i = (cyc_n == ack_at) ? sd : $urandom;
            end else begin
                if (stb_o !== 1'b0 || sel_o !== 1'b0 || we_o !== 1'b0 ||
                    addr_o !== 32'd0 || data_o !== 32'd0)
                    bus_ok = 0;
                ack_i  = 1'b0;
                data_i = $urandom;
            end
            if (resp_valid_o) begin
                resp_n++;
                if (resp_t < 0) begin
                    resp_t = t; rd = resp_rdata_o; er = resp_err_o; stop_t = t + 2;
                end
            end
            if (resp_t > 0 && t == resp_t + 1) begin
                rd_hold = resp_rdata_o; er_hold = resp_err_o; ready_after = req_ready_o;
            end
        end
        req_valid_i = 1'b0;
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++;
        if ({cyc_o, stb_o, sel_o, we_o, resp_valid_o, resp_err_o} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {cyc_o, stb_o, sel_o, we_o, resp_valid_o, resp_err_o});
        end
        checks++;
        if ({addr_o, data_o, resp_rdata_o} !== 96'd0) begin
            failures++; $display("FAIL reset_data addr=%h data=%h rdata=%h exp=0", addr_o, data_o, resp_rdata_o);
        end
    endtask

    task automatic test_read();
        int cn, ft, rn, rt; logic [31:0] rd, rh; logic er, eh, ra; bit ok;
        do_txn(32'h0000_0010, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, cn, ft, rn, rt, rd, er, rh, eh, ok, ra);
        checks++; if (cn !== 2) begin failures++; $display("FAIL read_cyc_len got=%0d exp=2", cn); end
        checks++; if (ft !== 1) begin failures++; $display("FAIL read_cyc_start got=%0d exp=1", ft); end
        checks++; if (rn !== 1 || rt !== 3) begin failures++; $display("FAIL read_resp count=%0d at=%0d exp=1 at 3", rn, rt); end
        checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("FAIL read_data got=%h err=%b exp=deadbeef err=0", rd, er); end
        checks++; if (!ok) begin failures++; $display("FAIL read_bus_signals got=bad exp=stable"); end
    endtask

    task automatic test_write();
        int cn, ft, rn, rt; logic [31:0] rd, rh; logic er, eh, ra; bit ok;
        do_txn(32'h20, 32'h1234_5678, 1'b1, 1, 32'hFFFF_FFFF, cn, ft, rn, rt, rd, er, rh, eh, ok, ra);
        checks++; if (!ok) begin failures++; $display("FAIL write_bus_signals got=bad exp=data 12345678 we 1"); end
        checks++; if (cn !== 1 || rn !== 1) begin failures++; $display("FAIL write_timing cyc=%0d resp=%0d exp=1 1", cn, rn); end
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL write_resp got=%h err=%b exp=0 err=0", rd, er); end
        checks++; if (ra !== 1'b1) begin failures++; $display("FAIL write_ready_after got=%b exp=1", ra); end
    endtask

    task automatic test_timeout();
        int cn, ft, rn, rt; logic [31:0] rd, rh; logic er, eh, ra; bit ok;
        do_txn(32'h40, 32'h0, 1'b0, 0, 32'h0, cn, ft, rn, rt, rd, er, rh, eh, ok, ra);
        checks++; if (cn !== TO) begin failures++; $display("FAIL timeout_cyc_len got=%0d exp=%0d", cn, TO); end
        checks++; if (rn !== 1 || rt !== TO + 1) begin failures++; $display("FAIL timeout_resp count=%0d at=%0d exp=1 at %0d", rn, rt, TO + 1); end
        checks++; if (rd !== 32'd0 || er !== 1'b1) begin failures++; $display("FAIL timeout_result got=%h err=%b exp=0 err=1", rd, er); end
        checks++; if (rh !== 32'd0 || eh !== 1'b1) begin failures++; $display("FAIL timeout_hold got=%h err=%b exp=0 err=1", rh, eh); end
    endtask

    task automatic test_race();
        int cn, ft, rn, rt; logic [31:0] rd, rh; logic er, eh, ra; bit ok;
        do_txn(32'h44, 32'h0, 1'b0, TO, 32'hA5A5_A5A5, cn, ft, rn, rt, rd, er, rh, eh, ok, ra);
        checks++; if (cn !== TO) begin failures++; $display("FAIL race_cyc_len got=%0d exp=%0d", cn, TO); end
        checks++; if (rd !== 32'hA5A5_A5A5 || er !== 1'b0) begin failures++; $display("FAIL race_result got=%h err=%b exp=a5a5a5a5 err=0", rd, er); end
    endtask

    task automatic test_reset_mid_bus();
        bit quiet;
        req_valid_i = 1'b1; req_addr_i = 32'h88; req_we_i = 1'b0; req_wdata_i = 32'h0;
        @(negedge clk_i);
        checks++; if (cyc_o !== 1'b1) begin failures++; $display("FAIL rstbus_enter got=%b exp=1", cyc_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            failures++; $display("FAIL rstbus_drop cyc=%b stb=%b ready=%b resp=%b exp=0 0 1 0", cyc_o, stb_o, req_ready_o, resp_valid_o);
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        quiet = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            ack_i = (t == 1);
            data_i = 32'hCAFE_F00D;
            if (resp_valid_o !== 1'b0 || cyc_o !== 1'b0 || req_ready_o !== 1'b1 || resp_rdata_o !== 32'd0) quiet = 0;
        end
        ack_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            if (resp_valid_o !== 1'b0 || cyc_o !== 1'b0 || req_ready_o !== 1'b1 || resp_rdata_o !== 32'd0) quiet = 0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL stray_ack got=activity exp=idle"); end
    endtask

    task automatic test_back_to_back();
        int starts[2]; logic [31:0] seen[2]; logic [31:0] rds[2]; int n, rn; logic prev;
        logic [31:0] a0, a1, d0, d1;
        a0 = $urandom; a1 = a0 ^ 32'h0000_1000; d0 = $urandom; d1 = ~d0;
        n = 0; rn = 0; prev = 1'b0; starts[0] = -1; starts[1] = -1;
        req_valid_i = 1'b1; req_addr_i = a0; req_we_i = 1'b0; req_wdata_i = 32'h0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk_i);
            if (cyc_o && !prev && n < 2) begin
                starts[n] = t; seen[n] = addr_o; n++;
                if (n == 1) req_addr_i = a1;
                else req_valid_i = 1'b0;
            end
            if (resp_valid_o && rn < 2) begin rds[rn] = resp_rdata_o; rn++; end
            prev = cyc_o;
            ack_i = cyc_o;
            data_i = (n == 1) ? d0 : d1;
        end
        ack_i = 1'b0; req_valid_i = 1'b0;
        checks++; if (n !== 2 || starts[1] - starts[0] !== 3) begin failures++; $display("FAIL b2b_interval got=%0d exp=3 (n=%0d)", starts[1] - starts[0], n); end
        checks++; if (seen[0] !== a0 || seen[1] !== a1) begin failures++; $display("FAIL b2b_addr got=%h,%h exp=%h,%h", seen[0], seen[1], a0, a1); end
        checks++; if (rn !== 2 || rds[0] !== d0 || rds[1] !== d1) begin failures++; $display("FAIL b2b_data count=%0d got=%h,%h exp=%h,%h", rn, rds[0], rds[1], d0, d1); end
    endtask

    task automatic test_random();
        int cn, ft, rn, rt, ack_at, exp_cyc; logic [31:0] rd, rh, a, wd, sd, exp_rd; logic er, eh, ra, w, exp_err; bit ok;
        for (int i = 0; i < 25; i++) begin
            a = $urandom; wd = $urandom; sd = $urandom; w = 1'($urandom_range(0, 1));
            ack_at = $urandom_range(0, TO + 2);
            exp_err = (ack_at == 0 || ack_at > TO);
            exp_cyc = exp_err ? TO : ack_at;
            exp_rd  = (exp_err || w) ? 32'd0 : sd;
            do_txn(a, wd, w, ack_at, sd, cn, ft, rn, rt, rd, er, rh, eh, ok, ra);
            checks++;
            if (cn !== exp_cyc || ft !== 1 || rn !== 1 || rt !== exp_cyc + 1) begin
                failures++; $display("FAIL rand_timing[%0d] cyc=%0d start=%0d resp=%0d at=%0d exp cyc=%0d resp at %0d", i, cn, ft, rn, rt, exp_cyc, exp_cyc + 1);
            end
            checks++;
            if (rd !== exp_rd || er !== exp_err || rh !== exp_rd || eh !== exp_err) begin
                failures++; $display("FAIL rand_result[%0d] got=%h err=%b hold=%h exp=%h err=%b", i, rd, er, rh, exp_rd, exp_err);
            end
            checks++;
            if (!ok || ra !== 1'b1) begin failures++; $display("FAIL rand_bus[%0d] ok=%0d ready=%b exp=1 1", i, ok, ra); end
        end
    endtask

    initial begin
        rst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        req_we_i = 1'b0; data_i = 32'h0; ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_race();
        test_reset_mid_bus();
        test_back_to_back();
        @(negedge clk_i);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
